cpu_rom_select: RTL and testbench

Registered address decoder and wait-state generator for the CPU PCB program ROM bank. It samples the Z80 memory-request strobes and the upper address lines, then drives the six active-low ROM chip enables (ROM0_AL..ROM5_AL) and the shared output enable MR_AL into the program ROM stage. It inserts a programmable number of WAIT_AL cycles on each ROM read and flags attempted writes into ROM space.

---
 rtl/cpu_rom_select.sv | 164 ++++++++++++++++
 tb/tb_cpu_rom_select.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_rom_select.sv
// Program ROM bank decoder for the CPU PCB: registered chip enables, shared output
// enable, programmable read wait states and a write-into-ROM error strobe.
module cpu_rom_select #(
  parameter int WAIT_CYCLES = 1,
  parameter int ROM_COUNT   = 6
) (
  input  logic CLK,
  input  logic RESET_AL,
  input  logic MREQ_AL,
  input  logic RD_AL,
  input  logic WR_AL,
  input  logic RFSH_AL,
  input  logic A12,
  input  logic A13,
  input  logic A14,
  input  logic A15,
  output logic ROM0_AL,
  output logic ROM1_AL,
  output logic ROM2_AL,
  output logic ROM3_AL,
  output logic ROM4_AL,
  output logic ROM5_AL,
  output logic MR_AL,
  output logic WAIT_AL,
  output logic ROM_WR_ERR_AL
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] ROM_LIMIT = 4'(ROM_COUNT);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] bank_q, bank_d;
  logic [5:0] sel_q, sel_d;
  logic       mr_q, mr_d;
  logic       wait_q, wait_d;
  logic       err_q, err_d;
  logic       wr_seen_q, wr_seen_d;

  logic [3:0] bank_idx;
  logic       rd_req;
  logic       wr_req;
  logic       strobe_release;
  logic       in_rom;
  logic       accept;

  assign bank_idx       = {A15, A14, A13, A12};
  assign rd_req         = ~MREQ_AL & ~RD_AL & RFSH_AL;
  assign wr_req         = ~MREQ_AL & ~WR_AL & RFSH_AL;
  assign strobe_release = MREQ_AL | RD_AL;
  assign in_rom         = (bank_idx < ROM_LIMIT);
  assign accept         = (state_q == ST_IDLE) && rd_req && in_rom;

  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      bank_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  // Bank is captured only on acceptance so later address movement cannot retarget the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    bank_d  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bank_d = bank_idx[2:0];
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (strobe_release) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (strobe_release) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and flopped, so pins never see input glitches.
  always_comb begin
    sel_d  = 6'h3F;
    mr_d   = 1'b1;
    wait_d = 1'b1;
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < 6; i++) begin
        if (bank_d == 3'(i)) begin
          sel_d[i] = 1'b0;
        end
      end
      mr_d   = 1'b0;
      wait_d = (state_d != ST_WAIT);
    end
  end

  always_comb begin
    err_d     = 1'b1;
    wr_seen_d = wr_seen_q;
    if (MREQ_AL) begin
      wr_seen_d = 1'b0;
    end else if (wr_req && in_rom && !wr_seen_q) begin
      err_d     = 1'b0;
      wr_seen_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      sel_q     <= 6'h3F;
      mr_q      <= 1'b1;
      wait_q    <= 1'b1;
      err_q     <= 1'b1;
      wr_seen_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      mr_q      <= mr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      wr_seen_q <= wr_seen_d;
    end
  end

  assign ROM0_AL       = sel_q[0];
  assign ROM1_AL       = sel_q[1];
  assign ROM2_AL       = sel_q[2];
  assign ROM3_AL       = sel_q[3];
  assign ROM4_AL       = sel_q[4];
  assign ROM5_AL       = sel_q[5];
  assign MR_AL         = mr_q;
  assign WAIT_AL       = wait_q;
  assign ROM_WR_ERR_AL = err_q;

endmodule

// File: tb/tb_cpu_rom_select.sv
// Bench for cpu_rom_select: four parameter variants share one stimulus stream and are
// checked every cycle against a transaction-level model plus literal spot checks.
module tb_cpu_rom_select;

  // Variants: 0 = wait1/rom6, 1 = wait0/rom6, 2 = wait7/rom6, 3 = wait1/rom4
  localparam logic [3:0][2:0] WC_P = {3'd1, 3'd7, 3'd0, 3'd1};
  localparam logic [3:0][2:0] RC_P = {3'd4, 3'd6, 3'd6, 3'd6};

  logic        CLK = 1'b0;
  logic        RESET_AL;
  logic        MREQ_AL;
  logic        RD_AL;
  logic        WR_AL;
  logic        RFSH_AL;
  logic [15:0] addr;

  // Per variant: {err, wait, mr, rom5..rom0}
  wire [3:0][8:0] obs;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  bit         m_active  [4];
  int         m_elapsed [4];
  int         m_bank    [4];
  bit         m_fired   [4];
  logic [8:0] m_exp     [4] = '{default: 9'h1FF};

  logic [15:0] sweep_addr [4] = '{16'h0000, 16'h1FFF, 16'h5ABC, 16'h6000};
  logic [8:0]  sweep_exp  [4] = '{9'h1BE, 9'h1BD, 9'h19F, 9'h1FF};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_rom_select #(
      .WAIT_CYCLES(int'(WC_P[g])),
      .ROM_COUNT  (int'(RC_P[g]))
    ) u_dut (
      .CLK          (CLK),
      .RESET_AL     (RESET_AL),
      .MREQ_AL      (MREQ_AL),
      .RD_AL        (RD_AL),
      .WR_AL        (WR_AL),
      .RFSH_AL      (RFSH_AL),
      .A12          (addr[12]),
      .A13          (addr[13]),
      .A14          (addr[14]),
      .A15          (addr[15]),
      .ROM0_AL      (obs[g][0]),
      .ROM1_AL      (obs[g][1]),
      .ROM2_AL      (obs[g][2]),
      .ROM3_AL      (obs[g][3]),
      .ROM4_AL      (obs[g][4]),
      .ROM5_AL      (obs[g][5]),
      .MR_AL        (obs[g][6]),
      .WAIT_AL      (obs[g][7]),
      .ROM_WR_ERR_AL(obs[g][8])
    );
  end

  initial forever #5 CLK = ~CLK;

  // Access-level model: an accepted read stays active until a strobe release, with
  // WAIT_AL low for the first WAIT_CYCLES clocks of it.
  initial begin
    int  n;
    bit  rd;
    bit  wr;
    bit  err;
    forever begin
      @(posedge CLK or negedge RESET_AL);
      if (!RESET_AL) begin
        for (int i = 0; i < 4; i++) begin
          m_active[i]  = 1'b0;
          m_elapsed[i] = 0;
          m_bank[i]    = 0;
          m_fired[i]   = 1'b0;
          m_exp[i]     = 9'h1FF;
        end
      end else begin
        n  = int'(addr[15:12]);
        rd = !MREQ_AL && !RD_AL && RFSH_AL;
        wr = !MREQ_AL && !WR_AL && RFSH_AL;
        for (int i = 0; i < 4; i++) begin
          if (m_active[i]) begin
            if (MREQ_AL || RD_AL) m_active[i] = 1'b0;
            else m_elapsed[i] = m_elapsed[i] + 1;
          end else if (rd && n < int'(RC_P[i])) begin
            m_active[i]  = 1'b1;
            m_elapsed[i] = 1;
            m_bank[i]    = n;
          end
          err = wr && (n < int'(RC_P[i])) && !m_fired[i];
          if (MREQ_AL) m_fired[i] = 1'b0;
          else if (err) m_fired[i] = 1'b1;
          m_exp[i] = 9'h1FF;
          if (m_active[i]) begin
            m_exp[i][m_bank[i]] = 1'b0;
            m_exp[i][6] = 1'b0;
            if (m_elapsed[i] <= int'(WC_P[i])) m_exp[i][7] = 1'b0;
          end
          m_exp[i][8] = !err;
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (check_en) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs[i] !== m_exp[i]) begin
          errors++;
          $display("[TB] FAIL model_cmp inst%0d t=%0t: got %h expected %h", i, $time, obs[i], m_exp[i]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic mreq, input logic rd, input logic wr,
                               input logic rfsh, input logic [15:0] a);
    MREQ_AL = mreq;
    RD_AL   = rd;
    WR_AL   = wr;
    RFSH_AL = rfsh;
    addr    = a;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  initial begin
    RESET_AL = 1'b0;
    MREQ_AL  = 1'b1;
    RD_AL    = 1'b1;
    WR_AL    = 1'b1;
    RFSH_AL  = 1'b1;
    addr     = 16'h0000;
    repeat (2) @(negedge CLK);
    check_en = 1'b1;
    checkOutput("reset_state", obs[0], 9'h1FF);
    RESET_AL = 1'b1;
    repeat (2) applyStimulus(1, 1, 1, 1, 16'h0000);

    $display("[TB] read bank 2, one wait state");
    applyStimulus(0, 0, 1, 1, 16'h2123);
    checkOutput("rd_bank2_c1", obs[0], 9'h13B);
    checkOutput("rd_bank2_nowait_c1", obs[1], 9'h1BB);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(0, 0, 1, 1, 16'h2123);
      checkOutput("rd_bank2_hold", obs[0], 9'h1BB);
    end
    applyStimulus(1, 1, 1, 1, 16'h2123);
    checkOutput("rd_bank2_release", obs[0], 9'h1FF);

    $display("[TB] reset mid-hold");
    repeat (3) applyStimulus(0, 0, 1, 1, 16'h2123);
    checkOutput("pre_reset_hold", obs[0], 9'h1BB);
    #2 RESET_AL = 1'b0;
    #1 checkOutput("async_reset", obs[0], 9'h1FF);
    checkOutput("async_reset_w7", obs[2], 9'h1FF);
    applyStimulus(1, 1, 1, 1, 16'h2123);
    RESET_AL = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 1, 1, 16'h2123);
      checkOutput("post_reset_idle", obs[0], 9'h1FF);
    end
    applyStimulus(0, 0, 1, 1, 16'h2123);
    checkOutput("post_reset_fresh_rd", obs[0], 9'h13B);
    applyStimulus(1, 1, 1, 1, 16'h2123);

    $display("[TB] no-wait sweep");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, 1, sweep_addr[k]);
      checkOutput("nowait_sel", obs[1], sweep_exp[k]);
      applyStimulus(0, 0, 1, 1, sweep_addr[k]);
      applyStimulus(1, 1, 1, 1, sweep_addr[k]);
      checkOutput("nowait_release", obs[1], 9'h1FF);
    end

    $display("[TB] seven wait states, then abort");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 1, 1, 16'h3000);
      checkOutput("wait7", obs[2], (k <= 7) ? 9'h137 : 9'h1B7);
    end
    applyStimulus(1, 1, 1, 1, 16'h3000);
    checkOutput("wait7_release", obs[2], 9'h1FF);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 1, 16'h3000);
      checkOutput("abort_waiting", obs[2], 9'h137);
    end
    applyStimulus(0, 1, 1, 1, 16'h3000);
    checkOutput("abort_idle", obs[2], 9'h1FF);
    applyStimulus(1, 1, 1, 1, 16'h3000);

    $display("[TB] write detect");
    applyStimulus(0, 1, 0, 1, 16'h4010);
    checkOutput("wr_pulse", obs[0], 9'h0FF);
    checkOutput("wr_rom4_outside", obs[3], 9'h1FF);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 0, 1, 16'h4010);
      checkOutput("wr_single_pulse", obs[0], 9'h1FF);
    end
    applyStimulus(1, 1, 1, 1, 16'h4010);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 1, 16'hE000);
      checkOutput("wr_outside", obs[0], 9'h1FF);
    end
    applyStimulus(1, 1, 1, 1, 16'hE000);
    applyStimulus(0, 0, 0, 1, 16'h1000);
    checkOutput("wr_during_rd", obs[0], 9'h03D);
    applyStimulus(0, 0, 0, 1, 16'h1000);
    checkOutput("wr_during_rd_hold", obs[0], 9'h1BD);
    applyStimulus(1, 1, 1, 1, 16'h1000);

    $display("[TB] refresh and rom count");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 1, 0, 16'h1000);
      checkOutput("refresh_ignored", obs[0], 9'h1FF);
    end
    applyStimulus(1, 1, 1, 1, 16'h1000);
    applyStimulus(0, 0, 1, 1, 16'h4000);
    checkOutput("rom4_outside", obs[3], 9'h1FF);
    checkOutput("rom6_bank4", obs[0], 9'h12F);
    applyStimulus(0, 0, 1, 1, 16'h4000);
    checkOutput("rom4_outside_c2", obs[3], 9'h1FF);
    repeat (2) applyStimulus(1, 1, 1, 1, 16'h0000);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
